decode: RTL

Second stage of the five-stage MIPS-subset pipeline: consumes the instruction word and next-PC latched by fetch, reads the 32×32 register file, resolves branches/jumps/traps back to fetch in the same cycle, and registers operands and control into the decode/execute pipeline register. It owns the architectural register file, whose write port is driven by writeback, and the exception PC register (EPC). Branches have one architectural delay slot: the instruction fetched alongside a taken branch always executes, and decode never squashes it.

---
 rtl/isa_pkg.sv | 60 ++++++
 rtl/regfile.sv | 47 ++++
 rtl/decode.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/isa_pkg.sv
// ============================================================================
// Module      : isa_pkg
// Description : MIPS-subset opcode/funct encodings, ALU and PC-select codes,
//               decode/execute control bundle. Shared by fetch, decode, execute.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package isa_pkg;

   localparam logic [31:0] TRAP_VECTOR = 32'h0000_0040;

   localparam logic [5:0] c_op_rtype = 6'h00;
   localparam logic [5:0] c_op_j     = 6'h02;
   localparam logic [5:0] c_op_jal   = 6'h03;
   localparam logic [5:0] c_op_beq   = 6'h04;
   localparam logic [5:0] c_op_bne   = 6'h05;
   localparam logic [5:0] c_op_addi  = 6'h08;
   localparam logic [5:0] c_op_lw    = 6'h23;
   localparam logic [5:0] c_op_sw    = 6'h2B;

   localparam logic [5:0] c_fn_jr    = 6'h08;
   localparam logic [5:0] c_fn_add   = 6'h20;
   localparam logic [5:0] c_fn_sub   = 6'h22;
   localparam logic [5:0] c_fn_and   = 6'h24;
   localparam logic [5:0] c_fn_or    = 6'h25;
   localparam logic [5:0] c_fn_slt   = 6'h2A;

   localparam logic [2:0] c_alu_add  = 3'b000;
   localparam logic [2:0] c_alu_sub  = 3'b001;
   localparam logic [2:0] c_alu_and  = 3'b010;
   localparam logic [2:0] c_alu_or   = 3'b011;
   localparam logic [2:0] c_alu_slt  = 3'b100;

   localparam logic [4:0] c_link_reg = 5'd31;

   typedef enum logic [1:0] {
      PC_BRANCH = 2'b00,
      PC_JR     = 2'b01,
      PC_JUMP   = 2'b10,
      PC_TRAP   = 2'b11
   } pctype_e;

   typedef struct packed {
      logic       regwrite;
      logic       memread;
      logic       memwrite;
      logic       link;
      logic       alusrc;
      logic [2:0] aluop;
      logic [4:0] regdest;
   } idex_ctrl_t;

   function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
      return {{16{imm[15]}}, imm};
   endfunction

endpackage

`default_nettype wire

// File: rtl/regfile.sv
// ============================================================================
// Module      : regfile
// Description : 32x32 register file, two combinational read ports with
//               write-through bypass, one synchronous write port, r0 fixed 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile (
   input  logic        clock,
   input  logic        reset,
   input  logic [4:0]  i_rs_addr,
   input  logic [4:0]  i_rt_addr,
   output logic [31:0] o_rs_data,
   output logic [31:0] o_rt_data,
   input  logic        i_wr_en,
   input  logic [4:0]  i_wr_addr,
   input  logic [31:0] i_wr_data
);

   logic [31:0] r_mem [32];
   logic [4:0]  w_rd_addr [2];
   logic [31:0] w_rd_data [2];

   assign w_rd_addr[0] = i_rs_addr;
   assign w_rd_addr[1] = i_rt_addr;
   assign o_rs_data    = w_rd_data[0];
   assign o_rt_data    = w_rd_data[1];

   // A write landing this cycle is visible to a read of the same register.
   for (genvar p = 0; p < 2; p++) begin : g_rd_port
      assign w_rd_data[p] = (w_rd_addr[p] == 5'd0)                   ? 32'h0 :
                            (i_wr_en && i_wr_addr == w_rd_addr[p])   ? i_wr_data :
                                                                       r_mem[w_rd_addr[p]];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) r_mem[i] <= 32'h0;
      end else if (i_wr_en && i_wr_addr != 5'd0) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

endmodule

`default_nettype wire

// File: rtl/decode.sv
// ============================================================================
// Module      : decode
// Description : Pipeline decode stage: register read, same-cycle branch/jump/
//               trap redirect to fetch, decode/execute register and EPC.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode import isa_pkg::*; #(
   parameter logic [31:0] TRAP_VECTOR = 32'h0000_0040
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] if_id_instruc,
   input  logic [31:0] if_id_nextpc,
   input  logic        ex_if_stall,
   input  logic        wb_id_regwrite,
   input  logic [4:0]  wb_id_regdest,
   input  logic [31:0] wb_id_writedata,
   output logic        id_if_selpcsource,
   output logic [1:0]  id_if_selpctype,
   output logic [31:0] id_if_pcimd2ext,
   output logic [31:0] id_if_rega,
   output logic [31:0] id_if_pcindex,
   output logic [31:0] id_ex_rega,
   output logic [31:0] id_ex_regb,
   output logic [31:0] id_ex_imedext,
   output logic [4:0]  id_ex_regdest,
   output logic [2:0]  id_ex_aluop,
   output logic        id_ex_alusrc,
   output logic        id_ex_memread,
   output logic        id_ex_memwrite,
   output logic        id_ex_regwrite,
   output logic        id_ex_link,
   output logic [31:0] id_ex_nextpc,
   output logic [31:0] id_epc
);

   // Fetch hard-codes its own trap target; a mismatch would silently misroute traps.
   if (TRAP_VECTOR != isa_pkg::TRAP_VECTOR) begin : g_trap_vector_check
      $error("decode TRAP_VECTOR differs from isa_pkg::TRAP_VECTOR");
   end

   logic [5:0]  w_opcode, w_funct;
   logic [4:0]  w_rs, w_rt, w_rd;
   logic [31:0] w_immext, w_rs_data, w_rt_data;
   logic        w_illegal, w_is_jr, w_is_jump, w_take;
   idex_ctrl_t  w_ctrl;
   pctype_e     w_pctype;

   idex_ctrl_t  r_ctrl;
   logic [31:0] r_rega, r_regb, r_imedext, r_nextpc, r_epc;

   assign w_opcode = if_id_instruc[31:26];
   assign w_rs     = if_id_instruc[25:21];
   assign w_rt     = if_id_instruc[20:16];
   assign w_rd     = if_id_instruc[15:11];
   assign w_funct  = if_id_instruc[5:0];
   assign w_immext = sign_ext16(if_id_instruc[15:0]);

   regfile u_regfile (
      .clock     (clock),
      .reset     (reset),
      .i_rs_addr (w_rs),
      .i_rt_addr (w_rt),
      .o_rs_data (w_rs_data),
      .o_rt_data (w_rt_data),
      .i_wr_en   (wb_id_regwrite),
      .i_wr_addr (wb_id_regdest),
      .i_wr_data (wb_id_writedata)
   );

   always_comb begin
      w_ctrl    = '0;
      w_illegal = 1'b0;
      w_is_jr   = 1'b0;
      w_is_jump = 1'b0;
      w_take    = 1'b0;
      case (w_opcode)
         c_op_rtype: begin
            // The all-zero word is the NOP and must not trap on funct 0.
            if (if_id_instruc != 32'h0) begin
               w_ctrl.regwrite = 1'b1;
               w_ctrl.regdest  = w_rd;
               case (w_funct)
                  c_fn_add: w_ctrl.aluop = c_alu_add;
                  c_fn_sub: w_ctrl.aluop = c_alu_sub;
                  c_fn_and: w_ctrl.aluop = c_alu_and;
                  c_fn_or:  w_ctrl.aluop = c_alu_or;
                  c_fn_slt: w_ctrl.aluop = c_alu_slt;
                  c_fn_jr: begin
                     w_ctrl  = '0;
                     w_is_jr = 1'b1;
                  end
                  default: begin
                     w_ctrl    = '0;
                     w_illegal = 1'b1;
                  end
               endcase
            end
         end
         c_op_addi: begin
            w_ctrl.regwrite = 1'b1;
            w_ctrl.alusrc   = 1'b1;
            w_ctrl.regdest  = w_rt;
         end
         c_op_lw: begin
            w_ctrl.regwrite = 1'b1;
            w_ctrl.memread  = 1'b1;
            w_ctrl.alusrc   = 1'b1;
            w_ctrl.regdest  = w_rt;
         end
         c_op_sw: begin
            w_ctrl.memwrite = 1'b1;
            w_ctrl.alusrc   = 1'b1;
         end
         c_op_beq: w_take = (w_rs_data == w_rt_data);
         c_op_bne: w_take = (w_rs_data != w_rt_data);
         c_op_j:   w_is_jump = 1'b1;
         c_op_jal: begin
            w_is_jump       = 1'b1;
            w_ctrl.regwrite = 1'b1;
            w_ctrl.link     = 1'b1;
            w_ctrl.regdest  = c_link_reg;
         end
         default: w_illegal = 1'b1;
      endcase
   end

   always_comb begin
      if (w_illegal)      w_pctype = PC_TRAP;
      else if (w_is_jr)   w_pctype = PC_JR;
      else if (w_is_jump) w_pctype = PC_JUMP;
      else                w_pctype = PC_BRANCH;
   end

   assign id_if_selpcsource = (w_take | w_is_jr | w_is_jump | w_illegal) & ~reset & ~ex_if_stall;
   assign id_if_selpctype   = w_pctype;
   assign id_if_pcimd2ext   = if_id_nextpc + {w_immext[29:0], 2'b00};
   assign id_if_rega        = w_rs_data;
   assign id_if_pcindex     = {if_id_nextpc[31:28], if_id_instruc[25:0], 2'b00};

   always_ff @(posedge clock) begin
      if (reset) begin
         r_ctrl    <= '0;
         r_rega    <= 32'h0;
         r_regb    <= 32'h0;
         r_imedext <= 32'h0;
         r_nextpc  <= 32'h0;
         r_epc     <= 32'h0;
      end else if (!ex_if_stall) begin
         r_ctrl    <= w_illegal ? '0 : w_ctrl;
         r_rega    <= w_rs_data;
         r_regb    <= w_rt_data;
         r_imedext <= w_immext;
         r_nextpc  <= if_id_nextpc;
         if (w_illegal) r_epc <= if_id_nextpc - 32'd4;
      end
   end

   assign id_ex_rega     = r_rega;
   assign id_ex_regb     = r_regb;
   assign id_ex_imedext  = r_imedext;
   assign id_ex_regdest  = r_ctrl.regdest;
   assign id_ex_aluop    = r_ctrl.aluop;
   assign id_ex_alusrc   = r_ctrl.alusrc;
   assign id_ex_memread  = r_ctrl.memread;
   assign id_ex_memwrite = r_ctrl.memwrite;
   assign id_ex_regwrite = r_ctrl.regwrite;
   assign id_ex_link     = r_ctrl.link;
   assign id_ex_nextpc   = r_nextpc;
   assign id_epc         = r_epc;

endmodule

`default_nettype wire
